// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// width of the packed BCD rendering of a 2N-bit quotient.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } divState_t;

   // Number of BCD bits needed to show a 2N-bit binary value: one decimal
   // digit per three binary bits, plus one digit of headroom.
   function automatic int bcdWidth(input int n);
      return (((2 * n) / 3) + 1) * 4;
   endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational binary to packed BCD converter (double-dabble / shift-add-3).
// Least significant decimal digit lands in bits [3:0] of the output.
module bin2bcd #(
   parameter int W  = 10,
   parameter int BW = ((W / 3) + 1) * 4
) (
   input  logic [W-1:0]  bin_i,
   output logic [BW-1:0] bcd_o
);

   logic [W+BW-1:0] scratch;

   // Shift the binary value into the digit field one bit at a time, adding 3
   // to every digit that is 5 or more before each shift so it carries as decimal.
   always_comb begin
      scratch          = '0;
      scratch[W-1:0]   = bin_i;
      for (int i = 0; i < W; i++) begin
         for (int d = 0; d < BW / 4; d++) begin
            if (scratch[W+4*d +: 4] >= 4'd5) begin
               scratch[W+4*d +: 4] = scratch[W+4*d +: 4] + 4'd3;
            end
         end
         scratch = scratch << 1;
      end
      bcd_o = scratch[W +: BW];
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, MSB first. A rising edge on start captures the operands;
// finish rises 2N+1 edges later (counting the capture edge) and the results
// hold until the next capture. A zero divisor finishes one edge after capture
// with an all-ones quotient and div_by_zero set.
// Optional feature: define SEQ_DIVIDER_BCD_EN to drive bcd with a registered
// decimal rendering of the quotient; otherwise bcd is tied to zero.
module seq_divider
   import divider_pkg::*;
#(
   parameter int N = 5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [2*N-1:0]          dividend,
   input  logic [N-1:0]            divisor,
   output logic [2*N-1:0]          quotient,
   output logic [N-1:0]            remainder,
   output logic                    finish,
   output logic                    div_by_zero,
   output logic [bcdWidth(N)-1:0]  bcd
);

   localparam int W  = 2 * N;
   localparam int BW = bcdWidth(N);
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

   divState_t        state_q, state_d;
   logic             start_q, start_d;
   logic             primed_q, primed_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W-1:0]     dvd_q, dvd_d;
   logic [N-1:0]     dvs_q, dvs_d;
   logic [N-1:0]     rem_q, rem_d;
   logic [W-1:0]     quotient_q, quotient_d;
   logic [N-1:0]     remainder_q, remainder_d;
   logic             finish_q, finish_d;
   logic             dbz_q, dbz_d;

   logic             startEdge;
   logic             divisorZero;
   logic             lastStep;
   logic             capture;
   logic             step;
   logic             loadResult;

   logic [N:0]       partial;
   logic             fits;
   logic [N-1:0]     remStep;
   logic [W-1:0]     dvdStep;

   // primed_q stays low for the first edge after reset so that a start
   // already high at reset release is sampled but never seen as an edge.
   assign startEdge   = primed_q & start & ~start_q;
   assign divisorZero = (dvs_q == '0);
   assign lastStep    = (cnt_q == LAST_STEP);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: only IDLE and DONE listen to start; RUN runs to completion.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (startEdge) state_d = RUN;
         RUN:        if (divisorZero || lastStep) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // Control decode: when to capture operands, iterate, and publish results.
   always_comb begin
      capture    = 1'b0;
      step       = 1'b0;
      loadResult = 1'b0;
      unique case (state_q)
         IDLE, DONE: capture = startEdge;
         RUN: begin
            step       = ~divisorZero;
            loadResult = divisorZero | lastStep;
         end
         default: begin
            capture    = 1'b0;
         end
      endcase
   end

   // One restoring step: shift the next dividend bit into the (N+1)-bit
   // partial remainder, subtract the divisor when it fits, and shift the
   // resulting quotient bit into the vacated low end of the dividend register.
   always_comb begin
      partial = {rem_q, dvd_q[W-1]};
      fits    = (partial >= {1'b0, dvs_q});
      remStep = fits ? (partial[N-1:0] - dvs_q) : partial[N-1:0];
      dvdStep = {dvd_q[W-2:0], fits};
   end

   // Datapath next-state: capture, iterate, and load the visible results.
   always_comb begin
      start_d     = start;
      primed_d    = 1'b1;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      finish_d    = finish_q;
      dbz_d       = dbz_q;

      if (capture) begin
         dvd_d    = dividend;
         dvs_d    = divisor;
         rem_d    = '0;
         cnt_d    = '0;
         finish_d = 1'b0;
         dbz_d    = 1'b0;
      end else if (step) begin
         dvd_d = dvdStep;
         rem_d = remStep;
         cnt_d = cnt_q + 1'b1;
      end

      if (loadResult) begin
         finish_d = 1'b1;
         if (divisorZero) begin
            quotient_d  = '1;
            remainder_d = dvd_q[N-1:0];
            dbz_d       = 1'b1;
         end else begin
            quotient_d  = dvdStep;
            remainder_d = remStep;
            dbz_d       = 1'b0;
         end
      end
   end

   // Datapath registers; reset clears everything so an aborted run leaves no trace.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         start_q     <= 1'b0;
         primed_q    <= 1'b0;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         finish_q    <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         start_q     <= start_d;
         primed_q    <= primed_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         finish_q    <= finish_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign finish      = finish_q;
   assign div_by_zero = dbz_q;

`ifdef SEQ_DIVIDER_BCD_EN
   logic [BW-1:0] bcdNext;
   logic [BW-1:0] bcd_q;

   bin2bcd #(
      .W  (W),
      .BW (BW)
   ) u_bin2bcd (
      .bin_i (quotient_d),
      .bcd_o (bcdNext)
   );

   // Decimal copy of the quotient, refreshed on the same edge as the quotient.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bcd_q <= '0;
      end else if (loadResult) begin
         bcd_q <= bcdNext;
      end
   end

   assign bcd = bcd_q;
`else
   assign bcd = '0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=5): directed cases plus randomized
// operations compared against plain integer division.
module tb_seq_divider;

   localparam int N  = 5;
   localparam int W  = 2 * N;
   localparam int BW = ((W / 3) + 1) * 4;
   localparam bit BCD_ON =
`ifdef SEQ_DIVIDER_BCD_EN
      1'b1;
`else
      1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  dividend;
   logic [N-1:0]  divisor;
   logic [W-1:0]  quotient;
   logic [N-1:0]  remainder;
   logic          finish;
   logic          div_by_zero;
   logic [BW-1:0] bcd;

   int testsRun    = 0;
   int testsFailed = 0;

   seq_divider #(.N(N)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .finish      (finish),
      .div_by_zero (div_by_zero),
      .bcd         (bcd)
   );

   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Decimal digits of a value, least significant digit lowest.
   function automatic logic [BW-1:0] refBcd(input int value);
      logic [BW-1:0] r;
      int v;
      r = '0;
      v = value;
      for (int i = 0; i < BW / 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return BCD_ON ? r : '0;
   endfunction

   // Start one operation and count edges from capture (edge 1) to finish.
   // With disturb set, start and the operands are thrashed during the run.
   task automatic applyStimulus(input logic [W-1:0] dvd, input logic [N-1:0] dvs,
                                input bit disturb, output int edges);
      start = 1'b0;
      tick();
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      tick();
      edges = 1;
      checkOutput("finishClearedOnCapture", 32'(finish), 32'd0);
      while (finish !== 1'b1 && edges < 40) begin
         if (disturb && edges >= 2 && edges <= 5) begin
            dividend = W'($urandom);
            divisor  = N'($urandom);
            start    = (edges % 2 == 0) ? 1'b0 : 1'b1;
         end
         tick();
         edges++;
      end
   endtask

   task automatic verifyOp(input string tag, input logic [W-1:0] dvd,
                           input logic [N-1:0] dvs, input bit disturb);
      int edges;
      int a;
      int b;
      logic [W-1:0] expQ;
      logic [N-1:0] expR;
      int expLat;
      a = int'(dvd);
      b = int'(dvs);
      if (b == 0) begin
         expQ   = '1;
         expR   = dvd[N-1:0];
         expLat = 2;
      end else begin
         expQ   = W'(a / b);
         expR   = N'(a % b);
         expLat = 2 * N + 1;
      end
      applyStimulus(dvd, dvs, disturb, edges);
      checkOutput({tag, ".latency"},   32'(edges),       32'(expLat));
      checkOutput({tag, ".quotient"},  32'(quotient),    32'(expQ));
      checkOutput({tag, ".remainder"}, 32'(remainder),   32'(expR));
      checkOutput({tag, ".divByZero"}, 32'(div_by_zero), 32'(b == 0));
      checkOutput({tag, ".bcd"},       32'(bcd),         32'(refBcd(int'(expQ))));
      if (b != 0) begin
         checkOutput({tag, ".remLtDivisor"}, 32'(int'(remainder) < b), 32'd1);
         checkOutput({tag, ".identity"},
                     32'(int'(quotient) * b + int'(remainder)), 32'(a));
      end
      tick();
      tick();
      checkOutput({tag, ".holdFinish"},   32'(finish),   32'd1);
      checkOutput({tag, ".holdQuotient"}, 32'(quotient), 32'(expQ));
      checkOutput({tag, ".holdBcd"},      32'(bcd),      32'(refBcd(int'(expQ))));
   endtask

   initial begin
      int finishSeen;

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) tick();
      checkOutput("reset.quotient",  32'(quotient),    32'd0);
      checkOutput("reset.remainder", 32'(remainder),   32'd0);
      checkOutput("reset.finish",    32'(finish),      32'd0);
      checkOutput("reset.divByZero", 32'(div_by_zero), 32'd0);
      checkOutput("reset.bcd",       32'(bcd),         32'd0);
      reset = 1'b0;
      tick();

      verifyOp("d780by26",  10'd780,  5'd26, 1'b0);
      verifyOp("d169by13",  10'd169,  5'd13, 1'b0);
      verifyOp("d1023by31", 10'd1023, 5'd31, 1'b0);
      verifyOp("d1000by7",  10'd1000, 5'd7,  1'b0);
      verifyOp("d100by0",   10'd100,  5'd0,  1'b0);

      // Reset asserted mid-run on RUN edge 4, start left high through release.
      start = 1'b0;
      tick();
      dividend = 10'd555;
      divisor  = 5'd9;
      start    = 1'b1;
      tick();
      tick();
      tick();
      tick();
      checkOutput("abort.preFinish", 32'(finish), 32'd0);
      reset = 1'b1;
      #1;
      checkOutput("abort.quotient",  32'(quotient),    32'd0);
      checkOutput("abort.remainder", 32'(remainder),   32'd0);
      checkOutput("abort.finish",    32'(finish),      32'd0);
      checkOutput("abort.divByZero", 32'(div_by_zero), 32'd0);
      checkOutput("abort.bcd",       32'(bcd),         32'd0);
      tick();
      tick();
      reset = 1'b0;
      finishSeen = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (finish === 1'b1) finishSeen++;
      end
      checkOutput("heldStart.noFinish", 32'(finishSeen), 32'd0);
      checkOutput("heldStart.quotient", 32'(quotient),   32'd0);

      verifyOp("disturbed", 10'd873, 5'd19, 1'b1);

      for (int k = 0; k < 25; k++) begin
         verifyOp("random", W'($urandom), N'($urandom_range(0, 31)), (k % 5) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
